alu_result_buffer: RTL and testbench

Registered result stage directly downstream of the core's 16-bit combinational ALU. It samples the ALU result and flag together with the opcode and divisor that produced them, and classifies each result as valid or error. Results are held in a small first-word-fall-through queue with a valid/ready handshake toward writeback. It also keeps a sticky error flag for the core's control logic.

---
 rtl/alu_result_buffer.sv | 108 ++++++++++
 tb/tb_alu_result_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Registered result stage after the ALU: classifies each result as valid or error
// and holds it in a small first-word-fall-through queue toward writeback.
module alu_result_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             alu_op,
    input  logic [DATA_W-1:0]      in1,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic                   z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_z,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_flag,
    input  logic                   err_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] dataMem_q [DEPTH];
    logic              zMem_q    [DEPTH];
    logic              errMem_q  [DEPTH];

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              errFlag_q, errFlag_d;

    logic              push, pop;
    logic              entryErr;
    logic [DATA_W-1:0] entryData;
    logic              entryZ;

    // Handshake depends only on occupancy, so no in->out or ready->ready paths exist.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = dataMem_q[rdPtr_q];
    assign out_z     = zMem_q[rdPtr_q];
    assign out_err   = errMem_q[rdPtr_q];
    assign count     = count_q;
    assign err_flag  = errFlag_q;

    // Undefined opcodes and division/modulo by zero become canned error entries.
    always_comb begin
        entryErr  = (alu_op == 3'd0) || (alu_op == 3'd7) ||
                    (((alu_op == 3'd4) || (alu_op == 3'd5)) && (in1 == '0));
        entryData = entryErr ? '0 : alu_out;
        entryZ    = entryErr ? 1'b1 : z;
    end

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        errFlag_d = errFlag_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error outranks a clear arriving in the same cycle.
        if (push && entryErr) begin
            errFlag_d = 1'b1;
        end else if (err_clr) begin
            errFlag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            errFlag_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dataMem_q[i] <= '0;
                zMem_q[i]    <= 1'b0;
                errMem_q[i]  <= 1'b0;
            end
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            errFlag_q <= errFlag_d;
            if (push) begin
                dataMem_q[wrPtr_q] <= entryData;
                zMem_q[wrPtr_q]    <= entryZ;
                errMem_q[wrPtr_q]  <= entryErr;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations along directed scenarios.
module tb_alu_result_buffer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] alu_out;
    logic              z;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_z;
    logic              out_err;
    logic [2:0]        count;
    logic              err_flag;
    logic              err_clr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              z;
        logic              e;
    } entry_t;

    entry_t mq[$];
    logic   mFlag;

    alu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .in1(in1), .alu_out(alu_out), .z(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_z(out_z), .out_err(out_err),
        .count(count), .err_flag(err_flag), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an entry queue updated from the handshake rules at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mFlag = 1'b0;
        end else begin
            bit     doPush, doPop, isErr;
            entry_t e;
            doPush = in_valid && (mq.size() < DEPTH);
            doPop  = out_ready && (mq.size() > 0);
            isErr  = (alu_op == 0) || (alu_op == 7) || ((alu_op == 4 || alu_op == 5) && in1 == 0);
            if (doPop) void'(mq.pop_front());
            if (doPush) begin
                e.d = isErr ? 16'h0000 : alu_out;
                e.z = isErr ? 1'b1 : z;
                e.e = isErr;
                mq.push_back(e);
            end
            if (doPush && isErr) mFlag = 1'b1;
            else if (err_clr)    mFlag = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("count", int'(count), mq.size());
            checkOutput("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
            checkOutput("out_valid", int'(out_valid), int'(mq.size() != 0));
            checkOutput("err_flag", int'(err_flag), int'(mFlag));
            if (mq.size() != 0) begin
                checkOutput("head_data", int'(out_data), int'(mq[0].d));
                checkOutput("head_z", int'(out_z), int'(mq[0].z));
                checkOutput("head_err", int'(out_err), int'(mq[0].e));
            end
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] res, input logic zz, input logic rdy,
                                 input logic clr);
        in_valid  = v;
        alu_op    = op;
        in1       = a;
        alu_out   = res;
        z         = zz;
        out_ready = rdy;
        err_clr   = clr;
        @(negedge clk);
    endtask

    task automatic pushAdd(input logic [15:0] res);
        applyStimulus(1'b1, 3'd1, 16'h0001, res, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic popOne();
        applyStimulus(1'b0, 3'd1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_z", int'(out_z), 0);
        checkOutput("rst_out_err", int'(out_err), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_err_flag", int'(err_flag), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Single push and pop
        applyStimulus(1'b1, 3'd1, 16'h0003, 16'h0007, 1'b0, 1'b0, 1'b0);
        checkOutput("single_valid", int'(out_valid), 1);
        checkOutput("single_data", int'(out_data), 16'h0007);
        checkOutput("single_z", int'(out_z), 0);
        checkOutput("single_err", int'(out_err), 0);
        checkOutput("single_count", int'(count), 1);
        popOne();
        checkOutput("single_pop_count", int'(count), 0);
        checkOutput("single_pop_valid", int'(out_valid), 0);

        // Fill, refused fifth push, drain in order
        for (int i = 1; i <= 4; i++) pushAdd(16'(i));
        checkOutput("full_count", int'(count), 4);
        checkOutput("full_in_ready", int'(in_ready), 0);
        pushAdd(16'h0005);
        checkOutput("full_ignored_count", int'(count), 4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_order", int'(out_data), i);
            popOne();
        end
        checkOutput("drained_count", int'(count), 0);

        // Wrap-around of both pointers
        for (int i = 0; i < 3; i++) pushAdd(16'h0010 + 16'(i));
        for (int i = 0; i < 3; i++) popOne();
        for (int i = 0; i < 4; i++) pushAdd(16'h00A0 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            checkOutput("wrap_order", int'(out_data), 16'h00A0 + i);
            popOne();
        end

        // Error classification and sticky flag
        applyStimulus(1'b1, 3'd4, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
        checkOutput("div0_data", int'(out_data), 0);
        checkOutput("div0_z", int'(out_z), 1);
        checkOutput("div0_err", int'(out_err), 1);
        checkOutput("div0_flag", int'(err_flag), 1);
        applyStimulus(1'b1, 3'd1, 16'h0005, 16'h0055, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd5, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        checkOutput("set_wins_flag", int'(err_flag), 1);
        applyStimulus(1'b1, 3'd4, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
        checkOutput("err_count", int'(count), 4);
        applyStimulus(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_flag", int'(err_flag), 0);
        checkOutput("err_head0_err", int'(out_err), 1);
        popOne();
        checkOutput("err_head1_data", int'(out_data), 16'h0055);
        checkOutput("err_head1_err", int'(out_err), 0);
        popOne();
        checkOutput("err_head2_data", int'(out_data), 0);
        checkOutput("err_head2_err", int'(out_err), 1);
        popOne();
        checkOutput("err_head3_data", int'(out_data), 16'h0002);
        checkOutput("err_head3_err", int'(out_err), 0);
        popOne();
        applyStimulus(1'b1, 3'd7, 16'h0009, 16'h4444, 1'b0, 1'b0, 1'b0);
        checkOutput("op7_err", int'(out_err), 1);
        checkOutput("op7_flag", int'(err_flag), 1);
        applyStimulus(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Push with pop at count 2
        pushAdd(16'h00C0);
        pushAdd(16'h00C1);
        applyStimulus(1'b1, 3'd2, 16'h0001, 16'h00C2, 1'b0, 1'b1, 1'b0);
        checkOutput("pp2_count", int'(count), 2);
        checkOutput("pp2_head", int'(out_data), 16'h00C1);
        popOne();
        checkOutput("pp2_next", int'(out_data), 16'h00C2);
        popOne();

        // Push with pop at count 4: push refused
        for (int i = 0; i < 4; i++) pushAdd(16'h00D0 + 16'(i));
        applyStimulus(1'b1, 3'd3, 16'h0002, 16'h00D4, 1'b0, 1'b1, 1'b0);
        checkOutput("pp4_count", int'(count), 3);
        checkOutput("pp4_head", int'(out_data), 16'h00D1);
        applyStimulus(1'b1, 3'd0, 16'h0000, 16'h7777, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_rst_count", int'(count), 3);
        checkOutput("pre_rst_flag", int'(err_flag), 1);

        // Asynchronous reset between clock edges
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", int'(out_valid), 0);
        checkOutput("arst_in_ready", int'(in_ready), 1);
        checkOutput("arst_count", int'(count), 0);
        checkOutput("arst_err_flag", int'(err_flag), 0);
        checkOutput("arst_out_data", int'(out_data), 0);
        checkOutput("arst_out_err", int'(out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pushAdd(16'h0042);
        checkOutput("post_rst_data", int'(out_data), 16'h0042);
        popOne();
        applyStimulus(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
